// File: rtl/multicycle_cu_pkg.sv
// Shared definitions for the multicycle control unit (the cu_defs set):
// state codes, RV32I opcode values, mux-select encodings, ALU operation
// codes and the registered control-word payload.
package multicycle_cu_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALU_OP_W = 4;

  // FSM state codes; these are also the values reported on watch_stat.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_RR      = 4'd2,
    ST_EXI     = 4'd3,
    ST_EXB     = 4'd4,
    ST_EXU     = 4'd5,
    ST_MR      = 4'd6,
    ST_MW      = 4'd7,
    ST_WBI     = 4'd8,
    ST_WBF     = 4'd9,
    ST_WBM     = 4'd10,
    ST_WBP_JPR = 4'd11,
    ST_WBP_JPF = 4'd12,
    ST_BR      = 4'd13,
    ST_TRAP    = 4'd14
  } cu_state_e;

  // RV32I major opcodes (IR[6:0]).
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct7 pattern selecting SUB / SRA(I).
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // pc_update_sel
  localparam logic [1:0] PC_STEP = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_ALU  = 2'b10;

  // wb_sel
  localparam logic [1:0] WB_IMM  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_MDR  = 2'b10;
  localparam logic [1:0] WB_LINK = 2'b11;

  // ALU operand selects
  localparam logic LHS_A   = 1'b0;
  localparam logic LHS_P   = 1'b1;
  localparam logic RHS_B   = 1'b0;
  localparam logic RHS_IMM = 1'b1;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;

  // Registered control word; FETCH's ir_write/pc_write pulse is handled
  // separately because it follows imem_ack within the cycle.
  typedef struct packed {
    logic                imem_req;
    logic                dmem_req;
    logic                dmem_we;
    logic                pc_write;
    logic                regs_write;
    logic [1:0]          pc_update_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_lhs_sel;
    logic                alu_rhs_sel;
    logic [1:0]          wb_sel;
    logic                trap;
  } cu_ctrl_t;

  // Branch condition from funct3 and the ALU flags.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zf,
                                        input logic lt, input logic ltu);
    logic t;
    unique case (f3)
      3'b000:  t = zf;
      3'b001:  t = !zf;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multicycle_cu_alu_dec.sv
// cu_alu_dec: combinational ALU-operation decode for the multicycle CU.
// Ports: opcode/funct3/funct7 (instruction fields) in, alu_op out.
// R/I types decode funct3 (funct7 == 0100000 selects SUB/SRA); BRANCH
// compares with SUB; every other opcode uses ADD for address/PC math.
module cu_alu_dec
  import multicycle_cu_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic alt_c;
  assign alt_c = (funct7 == F7_ALT);

  // SUB only exists in R form; ADDI ignores funct7 (it is immediate data).
  always_comb begin
    alu_op = ALU_ADD;
    unique case (opcode)
      OPC_R, OPC_I: begin
        unique case (funct3)
          3'b000:  alu_op = (opcode == OPC_R && alt_c) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = alt_c ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_BRANCH: alu_op = ALU_SUB;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// multicycle_cu: control FSM for a multicycle RV32I datapath.
// Ports: clk, rst (async, active-high); instruction fields opcode/funct3/
// funct7; ALU flags zf/lt/ltu; memory acks imem_ack/dmem_ack. Outputs:
// memory requests, register enables, PC/ALU/writeback selects, trap and
// watch_stat (current state code).
// Configuration macro: MULTICYCLE_CU_TRAP_EN -- when defined, illegal
// instructions and memory waits of MEM_TIMEOUT cycles enter TRAP; when
// undefined, illegal instructions act as NOPs and waits are unbounded.
// Control outputs are registered from the next state, so they line up with
// watch_stat. ir_write/pc_write in FETCH follow imem_ack in the same cycle.
module multicycle_cu
  import multicycle_cu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STAT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              zf,
  input  logic              lt,
  input  logic              ltu,
  input  logic              imem_ack,
  input  logic              dmem_ack,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              pc_write,
  output logic              ir_write,
  output logic              regs_write,
  output logic [1:0]        pc_update_sel,
  output logic [3:0]        alu_op,
  output logic              alu_lhs_sel,
  output logic              alu_rhs_sel,
  output logic [1:0]        wb_sel,
  output logic              trap,
  output logic [STAT_W-1:0] watch_stat
);

  cu_state_e           state_q, state_d;
  cu_ctrl_t            ctrl_q, ctrl_d;
  logic [ALU_OP_W-1:0] alu_op_dec;
  logic                illegal_c;
  logic                fetch_ack_c;

  cu_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (alu_op_dec)
  );

`ifdef MULTICYCLE_CU_TRAP_EN
  // Consecutive no-ack cycles in the current memory state.
  localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic             mem_wait_c;
  logic             timeout_c;

  always_comb begin
    mem_wait_c = ((state_q == ST_FETCH) && !imem_ack) ||
                 ((state_q == ST_MR || state_q == ST_MW) && !dmem_ack);
    timeout_c  = (MEM_TIMEOUT != 0) && mem_wait_c &&
                 (wait_q == TMO_W'(MEM_TIMEOUT - 1));
    wait_d     = mem_wait_c ? wait_q + TMO_W'(1) : '0;
  end
`endif

  // Unknown opcodes and branch funct3 010/011 are illegal.
  always_comb begin
    illegal_c = 1'b0;
    unique case (opcode)
      OPC_R, OPC_I, OPC_LUI, OPC_AUIPC, OPC_LOAD,
      OPC_STORE, OPC_JAL, OPC_JALR: illegal_c = 1'b0;
      OPC_BRANCH: illegal_c = (funct3 == 3'b010) || (funct3 == 3'b011);
      default:    illegal_c = 1'b1;
    endcase
  end

  // Next-state and next control word.
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          if (illegal_c) begin
`ifdef MULTICYCLE_CU_TRAP_EN
            state_d = ST_TRAP;
`else
            state_d = ST_FETCH;
`endif
          end else begin
            unique case (opcode)
              OPC_LUI:   state_d = ST_WBI;
              OPC_AUIPC: state_d = ST_EXU;
              OPC_JAL:   state_d = ST_WBP_JPR;
              default:   state_d = ST_RR;
            endcase
          end
        end
`ifdef MULTICYCLE_CU_TRAP_EN
        else if (timeout_c) begin
          state_d = ST_TRAP;
        end
`endif
      end
      ST_RR: state_d = (opcode == OPC_R || opcode == OPC_BRANCH) ? ST_EXB : ST_EXI;
      ST_EXI: begin
        unique case (opcode)
          OPC_LOAD:  state_d = ST_MR;
          OPC_STORE: state_d = ST_MW;
          OPC_JALR:  state_d = ST_WBP_JPF;
          default:   state_d = ST_WBF;
        endcase
      end
      ST_EXB: state_d = (opcode == OPC_BRANCH) ? ST_BR : ST_WBF;
      ST_EXU: state_d = ST_WBF;
      ST_MR: begin
        if (dmem_ack) begin
          state_d = ST_WBM;
        end
`ifdef MULTICYCLE_CU_TRAP_EN
        else if (timeout_c) begin
          state_d = ST_TRAP;
        end
`endif
      end
      ST_MW: begin
        if (dmem_ack) begin
          state_d = ST_FETCH;
        end
`ifdef MULTICYCLE_CU_TRAP_EN
        else if (timeout_c) begin
          state_d = ST_TRAP;
        end
`endif
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Control word for the state being entered. BR's taken decision uses
    // the flags produced by the compare in EXB.
    unique case (state_d)
      ST_FETCH: ctrl_d.imem_req = 1'b1;
      ST_EXI: begin
        ctrl_d.alu_rhs_sel = RHS_IMM;
        ctrl_d.alu_op      = alu_op_dec;
      end
      ST_EXB: begin
        ctrl_d.alu_rhs_sel = RHS_B;
        ctrl_d.alu_op      = alu_op_dec;
      end
      ST_EXU: begin
        ctrl_d.alu_lhs_sel = LHS_P;
        ctrl_d.alu_rhs_sel = RHS_IMM;
        ctrl_d.alu_op      = alu_op_dec;
      end
      ST_MR: ctrl_d.dmem_req = 1'b1;
      ST_MW: begin
        ctrl_d.dmem_req = 1'b1;
        ctrl_d.dmem_we  = 1'b1;
      end
      ST_WBI: begin
        ctrl_d.regs_write = 1'b1;
        ctrl_d.wb_sel     = WB_IMM;
      end
      ST_WBF: begin
        ctrl_d.regs_write = 1'b1;
        ctrl_d.wb_sel     = WB_ALU;
      end
      ST_WBM: begin
        ctrl_d.regs_write = 1'b1;
        ctrl_d.wb_sel     = WB_MDR;
      end
      ST_WBP_JPR, ST_WBP_JPF: begin
        ctrl_d.regs_write    = 1'b1;
        ctrl_d.wb_sel        = WB_LINK;
        ctrl_d.pc_write      = 1'b1;
        ctrl_d.pc_update_sel = (state_d == ST_WBP_JPR) ? PC_REL : PC_ALU;
      end
      ST_BR: begin
        if (branch_taken(funct3, zf, lt, ltu)) begin
          ctrl_d.pc_write      = 1'b1;
          ctrl_d.pc_update_sel = PC_REL;
        end
      end
      ST_TRAP: ctrl_d.trap = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // State and control-word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
`ifdef MULTICYCLE_CU_TRAP_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
`ifdef MULTICYCLE_CU_TRAP_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // IR load and PC step happen in the FETCH cycle that sees the ack.
  assign fetch_ack_c = (state_q == ST_FETCH) && imem_ack;

  assign imem_req      = ctrl_q.imem_req;
  assign dmem_req      = ctrl_q.dmem_req;
  assign dmem_we       = ctrl_q.dmem_we;
  assign ir_write      = fetch_ack_c;
  assign pc_write      = ctrl_q.pc_write | fetch_ack_c;
  assign regs_write    = ctrl_q.regs_write;
  assign pc_update_sel = ctrl_q.pc_update_sel;
  assign alu_op        = ctrl_q.alu_op;
  assign alu_lhs_sel   = ctrl_q.alu_lhs_sel;
  assign alu_rhs_sel   = ctrl_q.alu_rhs_sel;
  assign wb_sel        = ctrl_q.wb_sel;
  assign trap          = ctrl_q.trap;
  assign watch_stat    = STAT_W'(state_q);

endmodule

// File: tb/tb_multicycle_cu.sv
// Testbench for multicycle_cu: directed instructions plus randomized
// instruction streams, wait states and stray acks, checked each cycle
// against a reference of the expected state sequence and per-state outputs.
module tb_multicycle_cu;
  import multicycle_cu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       zf, lt, ltu, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, pc_write, ir_write, regs_write;
  logic [1:0] pc_update_sel, wb_sel;
  logic [3:0] alu_op;
  logic       alu_lhs_sel, alu_rhs_sel, trap;
  logic [3:0] watch_stat;

  multicycle_cu dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zf(zf), .lt(lt), .ltu(ltu), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .ir_write(ir_write), .regs_write(regs_write),
    .pc_update_sel(pc_update_sel), .alu_op(alu_op), .alu_lhs_sel(alu_lhs_sel),
    .alu_rhs_sel(alu_rhs_sel), .wb_sel(wb_sel), .trap(trap),
    .watch_stat(watch_stat)
  );

  always #5 clk = ~clk;

  localparam int C_R = 0, C_I = 1, C_LUI = 2, C_AUIPC = 3, C_LOAD = 4,
                 C_STORE = 5, C_BR = 6, C_JAL = 7, C_JALR = 8, C_ILL = 9;

  int   total = 0;
  int   bad   = 0;
  logic [3:0] g_aop;
  logic       g_taken;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] opc_of(input int cls);
    case (cls)
      C_R:     return 7'h33;
      C_I:     return 7'h13;
      C_LUI:   return 7'h37;
      C_AUIPC: return 7'h17;
      C_LOAD:  return 7'h03;
      C_STORE: return 7'h23;
      C_BR:    return 7'h63;
      C_JAL:   return 7'h6F;
      C_JALR:  return 7'h67;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic bit is_known(input logic [6:0] opc);
    for (int c = C_R; c <= C_JALR; c++) if (opc_of(c) == opc) return 1'b1;
    return 1'b0;
  endfunction

  // RV32I operation selected by each instruction class.
  function automatic logic [3:0] ref_aop(input int cls, input logic [2:0] f3, input logic [6:0] f7);
    bit alt;
    alt = (f7 == 7'h20);
    if (cls == C_BR) return ALU_SUB;
    if (cls != C_R && cls != C_I) return ALU_ADD;
    case (f3)
      3'd0: return (cls == C_R && alt) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [2:0] flg);
    case (f3)
      3'd0: return flg[2];
      3'd1: return !flg[2];
      3'd4: return flg[1];
      3'd5: return !flg[1];
      3'd6: return flg[0];
      3'd7: return !flg[0];
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs {ireq,dreq,we,pcw,irw,rw,sel,aop,lhs,rhs,wb,trap}.
  function automatic logic [16:0] exp_vec(input cu_state_e st, input logic ia);
    logic ireq, dreq, we, pcw, irw, rw, lhs, rhs, tr;
    logic [1:0] sel, wb;
    logic [3:0] a;
    {ireq, dreq, we, pcw, irw, rw, lhs, rhs, tr} = '0;
    sel = 2'b00; wb = 2'b00; a = 4'h0;
    case (st)
      ST_FETCH:   begin ireq = 1; pcw = ia; irw = ia; end
      ST_EXI:     begin rhs = 1; a = g_aop; end
      ST_EXB:     begin a = g_aop; end
      ST_EXU:     begin lhs = 1; rhs = 1; a = g_aop; end
      ST_MR:      begin dreq = 1; end
      ST_MW:      begin dreq = 1; we = 1; end
      ST_WBI:     begin rw = 1; wb = 2'b00; end
      ST_WBF:     begin rw = 1; wb = 2'b01; end
      ST_WBM:     begin rw = 1; wb = 2'b10; end
      ST_WBP_JPR: begin rw = 1; wb = 2'b11; pcw = 1; sel = 2'b01; end
      ST_WBP_JPF: begin rw = 1; wb = 2'b11; pcw = 1; sel = 2'b10; end
      ST_BR:      begin pcw = g_taken; sel = g_taken ? 2'b01 : 2'b00; end
      ST_TRAP:    begin tr = 1; end
      default:    ;
    endcase
    return {ireq, dreq, we, pcw, irw, rw, sel, a, lhs, rhs, wb, tr};
  endfunction

  // alu_op only matters in execute states; pc_update_sel is free in a
  // not-taken BR.
  function automatic logic [16:0] act_vec(input cu_state_e st);
    logic [3:0] a;
    logic [1:0] s;
    a = (st == ST_EXI || st == ST_EXB || st == ST_EXU) ? alu_op : 4'h0;
    s = (st == ST_BR && !g_taken) ? 2'b00 : pc_update_sel;
    return {imem_req, dmem_req, dmem_we, pc_write, ir_write, regs_write, s, a,
            alu_lhs_sel, alu_rhs_sel, wb_sel, trap};
  endfunction

  function automatic logic stray();
    return 1'($urandom_range(0, 1));
  endfunction

  // Called at a falling edge: drive acks, check this cycle, move on.
  task automatic do_cycle(input cu_state_e st, input logic ia, input logic da, input string tag);
    imem_ack = ia;
    dmem_ack = da;
    #1;
    check({tag, "/state"}, 32'(watch_stat), 32'(st));
    check({tag, "/outs"}, 32'(act_vec(st)), 32'(exp_vec(st, ia)));
    @(negedge clk);
  endtask

  task automatic other(input cu_state_e st, input string tag);
    do_cycle(st, stray(), stray(), tag);
  endtask

  task automatic mem_phase(input cu_state_e st, input int dw, input string tag);
    for (int i = 0; i < dw; i++) do_cycle(st, stray(), 1'b0, tag);
    do_cycle(st, stray(), 1'b1, tag);
  endtask

  task automatic run_instr(input int cls, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [2:0] flg,
                           input int iw, input int dw, input string tag);
    opcode = opc; funct3 = f3; funct7 = f7;
    {zf, lt, ltu} = flg;
    g_aop   = ref_aop(cls, f3, f7);
    g_taken = (cls == C_BR) && ref_taken(f3, flg);
    for (int i = 0; i < iw; i++) do_cycle(ST_FETCH, 1'b0, stray(), tag);
    do_cycle(ST_FETCH, 1'b1, stray(), tag);
    case (cls)
      C_R:     begin other(ST_RR, tag); other(ST_EXB, tag); other(ST_WBF, tag); end
      C_I:     begin other(ST_RR, tag); other(ST_EXI, tag); other(ST_WBF, tag); end
      C_LUI:   other(ST_WBI, tag);
      C_AUIPC: begin other(ST_EXU, tag); other(ST_WBF, tag); end
      C_LOAD:  begin other(ST_RR, tag); other(ST_EXI, tag);
                     mem_phase(ST_MR, dw, tag); other(ST_WBM, tag); end
      C_STORE: begin other(ST_RR, tag); other(ST_EXI, tag); mem_phase(ST_MW, dw, tag); end
      C_BR:    begin other(ST_RR, tag); other(ST_EXB, tag); other(ST_BR, tag); end
      C_JAL:   other(ST_WBP_JPR, tag);
      C_JALR:  begin other(ST_RR, tag); other(ST_EXI, tag); other(ST_WBP_JPF, tag); end
      default: begin
`ifdef MULTICYCLE_CU_TRAP_EN
        for (int i = 0; i < 4; i++) other(ST_TRAP, tag);
`endif
      end
    endcase
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    do_cycle(ST_IDLE, stray(), stray(), {tag, "/in"});
    rst = 1'b0;
    do_cycle(ST_IDLE, 1'b0, 1'b0, {tag, "/rel"});
  endtask

  initial begin
    logic [2:0] br_f3 [6];
    int         cls, max_cls;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    rst = 1'b1; opcode = 7'h13; funct3 = 3'd0; funct7 = 7'd0;
    zf = 0; lt = 0; ltu = 0; imem_ack = 0; dmem_ack = 0;
    g_aop = ALU_ADD; g_taken = 1'b0;
    @(negedge clk);
    do_cycle(ST_IDLE, 1'b1, 1'b1, "reset");
    rst = 1'b0;
    do_cycle(ST_IDLE, 1'b0, 1'b0, "release");

    run_instr(C_R, 7'h33, 3'd0, 7'h00, 3'b000, 2, 0, "add");
    run_instr(C_BR, 7'h63, 3'd1, 7'h00, 3'b000, 0, 0, "bne_tk");
    run_instr(C_BR, 7'h63, 3'd1, 7'h00, 3'b100, 1, 0, "bne_nt");
    run_instr(C_LOAD, 7'h03, 3'd2, 7'h00, 3'b000, 0, 5, "lw");
    run_instr(C_JALR, 7'h67, 3'd0, 7'h00, 3'b000, 0, 0, "jalr");
    run_instr(C_R, 7'h33, 3'd5, 7'h20, 3'b000, 0, 0, "sra");
    run_instr(C_STORE, 7'h23, 3'd2, 7'h00, 3'b000, 0, 2, "sw");

    // Reset asserted while MW is waiting for its ack.
    opcode = 7'h23; funct3 = 3'd2; funct7 = 7'h00;
    g_aop = ALU_ADD; g_taken = 1'b0;
    do_cycle(ST_FETCH, 1'b1, 1'b0, "rstmw");
    other(ST_RR, "rstmw");
    other(ST_EXI, "rstmw");
    do_cycle(ST_MW, 1'b0, 1'b0, "rstmw");
    do_cycle(ST_MW, 1'b0, 1'b0, "rstmw");
    rst = 1'b1;
    #1;
    check("rstmw/dmem_req", 32'(dmem_req), 32'd0);
    check("rstmw/state", 32'(watch_stat), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    do_cycle(ST_IDLE, 1'b0, 1'b0, "rstmw/rel");

`ifdef MULTICYCLE_CU_TRAP_EN
    max_cls = C_JALR;
`else
    max_cls = C_ILL;
    run_instr(C_ILL, 7'h7F, 3'd0, 7'h00, 3'b000, 0, 0, "nop7f");
    run_instr(C_ILL, 7'h63, 3'd3, 7'h00, 3'b000, 0, 0, "nopbr");
    run_instr(C_I, 7'h13, 3'd0, 7'h00, 3'b000, 20, 0, "longwait");
`endif

    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, max_cls);
      opc = opc_of(cls);
      f3  = 3'($urandom);
      f7  = 7'($urandom);
      if (cls == C_R) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      if (cls == C_I && $urandom_range(0, 1) == 1) f7 = 7'h20;
      if (cls == C_BR) f3 = br_f3[$urandom_range(0, 5)];
      if (cls == C_ILL) begin
        if ($urandom_range(0, 1) == 1) begin
          opc = 7'h63;
          f3  = 3'($urandom_range(2, 3));
        end else begin
          do opc = 7'($urandom); while (is_known(opc));
        end
      end
      run_instr(cls, opc, f3, f7, 3'($urandom), $urandom_range(0, 4),
                $urandom_range(0, 6), "rnd");
    end

`ifdef MULTICYCLE_CU_TRAP_EN
    pulse_reset("t1");
    run_instr(C_ILL, 7'h7F, 3'd0, 7'h00, 3'b000, 1, 0, "ill7f");
    pulse_reset("t2");
    run_instr(C_ILL, 7'h63, 3'd2, 7'h00, 3'b000, 0, 0, "illbr");
    pulse_reset("t3");
    opcode = 7'h33; funct3 = 3'd0; funct7 = 7'h00; g_taken = 1'b0;
    for (int i = 0; i < 16; i++) do_cycle(ST_FETCH, 1'b0, stray(), "ftmo");
    for (int i = 0; i < 3; i++) other(ST_TRAP, "ftmo");
    pulse_reset("t4");
    opcode = 7'h03; funct3 = 3'd2; g_aop = ALU_ADD;
    do_cycle(ST_FETCH, 1'b1, 1'b0, "mrtmo");
    other(ST_RR, "mrtmo");
    other(ST_EXI, "mrtmo");
    for (int i = 0; i < 16; i++) do_cycle(ST_MR, stray(), 1'b0, "mrtmo");
    for (int i = 0; i < 2; i++) other(ST_TRAP, "mrtmo");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, cycles to wait for a memory ack before a fault; 0 means wait forever.
REQ-002 SHALL have parameter STAT_W, default 4, width of watch_stat.
REQ-003 SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- zf, lt, ltu  in  1 each  ALU equal, signed-less, unsigned-less flags.
- imem_ack, dmem_ack  in  1 each  memory completion.
- imem_req, dmem_req  out  1 each  memory request, held until ack.
- dmem_we  out  1  write strobe qualifier for dmem_req.
- pc_write, ir_write, regs_write  out  1 each  register enables.
- pc_update_sel  out  2  00 step (+4), 01 relative to P reg, 10 from F reg.
- alu_op  out  4  ALU operation.
- alu_lhs_sel  out  1  0 A reg, 1 P reg.
- alu_rhs_sel  out  1  0 B reg, 1 imm32.
- wb_sel  out  2  00 imm32, 01 F, 10 MDR, 11 P+4.
- trap  out  1  fault indication.
- watch_stat  out  STAT_W  current state.

Function
REQ-004 SHALL implement states IDLE, FETCH, RR, EXI, EXB, EXU, MR, MW, WBI, WBF, WBM, WBP_JPR, WBP_JPF, BR, TRAP.
REQ-005 SHALL register all outputs so that each state's output values are valid in exactly the cycles where watch_stat equals that state.
REQ-006 SHALL use these sequences (each ends back in FETCH):
- R: FETCH -> RR -> EXB -> WBF.
- I: FETCH -> RR -> EXI -> WBF.
- LUI: FETCH -> WBI.
- AUIPC: FETCH -> EXU -> WBF.
- LOAD: FETCH -> RR -> EXI -> MR -> WBM.
- STORE: FETCH -> RR -> EXI -> MW.
- BRANCH: FETCH -> RR -> EXB -> BR.
- JAL: FETCH -> WBP_JPR.
- JALR: FETCH -> RR -> EXI -> WBP_JPF.
REQ-007 SHALL go IDLE -> FETCH on the first clock edge after reset release.
REQ-008 FETCH SHALL hold imem_req=1; in the cycle imem_ack=1 it SHALL assert ir_write=1 and pc_write=1 with pc_update_sel=00, and leave FETCH on the next edge.
REQ-009 MR SHALL hold dmem_req=1 with dmem_we=0, and MW SHALL hold dmem_req=1 with dmem_we=1, each until dmem_ack; the state SHALL advance on the edge after ack.
REQ-010 EXU SHALL drive alu_lhs_sel=1 and alu_rhs_sel=1; EXI SHALL drive alu_rhs_sel=1; EXB SHALL drive alu_rhs_sel=0; all other states SHALL drive alu_lhs_sel=0.
REQ-011 BR SHALL evaluate the branch condition by funct3: 000 zf, 001 !zf, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
REQ-012 In BR, a taken branch SHALL assert pc_write=1 with pc_update_sel=01; a not-taken branch SHALL assert pc_write=0.
REQ-013 WBP_JPR SHALL assert regs_write=1, wb_sel=11, pc_write=1, pc_update_sel=01.
REQ-014 WBP_JPF SHALL assert the same as WBP_JPR except pc_update_sel=10.
REQ-015 WBI SHALL assert regs_write=1 with wb_sel=00; WBF with wb_sel=01; WBM with wb_sel=10. regs_write SHALL be 0 in every other state.
REQ-016 alu_op SHALL be: funct3/funct7-decoded for R and I types; ADD for LOAD, STORE, JALR, AUIPC; SUB for BRANCH.
REQ-017 An unknown opcode, or branch funct3 010/011, SHALL be treated as illegal (see REQ-022).
REQ-018 If imem_ack and dmem_ack are both asserted, only the ack belonging to the current state SHALL be honoured.

Reset
REQ-019 rst=1 SHALL force state IDLE immediately, including mid-FETCH, mid-MR or mid-MW.
REQ-020 Under reset, every enable, imem_req, dmem_req, dmem_we, trap, alu_lhs_sel, alu_rhs_sel and pc_update_sel SHALL be 0, and wb_sel SHALL be 00.

Configuration
REQ-021 Macro MULTICYCLE_CU_TRAP_EN SHALL select trap behaviour.
REQ-022 With MULTICYCLE_CU_TRAP_EN defined:
- an illegal instruction, or MEM_TIMEOUT consecutive cycles without ack in FETCH/MR/MW, SHALL move the FSM to TRAP;
- TRAP SHALL hold trap=1 with all enables 0 until reset.
REQ-023 Without MULTICYCLE_CU_TRAP_EN:
- an illegal instruction SHALL return to FETCH as a NOP;
- memory waits SHALL be unbounded;
- TRAP SHALL be unreachable and trap tied to 0.

Structure
REQ-024 State codes, opcode values, and pc_update_sel, wb_sel and lhs/rhs select encodings SHALL live in shared define files (cu_defs).
REQ-025 ALU-op decoding SHALL be a sub-module cu_alu_dec (opcode, funct3, funct7 -> alu_op).

Verification
REQ-026 ADD x3,x1,x2 with imem_ack after 2 wait cycles -> states FETCH(3 cycles), RR, EXB, WBF; regs_write=1, wb_sel=01 only in WBF.
REQ-027 BNE with zf=0 -> BR asserts pc_write=1, pc_update_sel=01; repeated with zf=1 -> pc_write=0 in BR.
REQ-028 LW with dmem_ack delayed 5 cycles -> MR holds dmem_req=1, dmem_we=0 for 6 cycles, then WBM with wb_sel=10.
REQ-029 rst pulsed during MW with dmem_req=1 -> dmem_req=0 and watch_stat=IDLE in the same cycle; FETCH on the first edge after release.
REQ-030 With trap enabled: opcode 7'h7F -> TRAP, trap=1; FETCH with no ack for 16 cycles -> TRAP.
REQ-031 JALR -> EXI with alu_op=ADD and alu_rhs_sel=1, then WBP_JPF with regs_write=1, wb_sel=11, pc_update_sel=10.
